// File: rtl/stopwatch_display_pkg.sv
// rtl/stopwatch_display_pkg.sv - shared states, glyphs and BCD step helper for the stopwatch display
package stopwatch_display_pkg;

   typedef enum logic [1:0] {CAPTURE, SHIFT, COMMIT} conv_state_e;

   localparam int CONV_SHIFTS = 7;
   localparam int DIGIT_COUNT = 6;
   localparam int SR_W        = 15;

   localparam logic [3:0] DIGIT_E = 4'hE;

   // Active-high glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // One shift-add-3 step on {tens, ones, binary}
   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
      logic [SR_W-1:0] t;
      t = sr;
      if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

endpackage

// File: rtl/stopwatch_seg_decoder.sv
// rtl/stopwatch_seg_decoder.sv - BCD digit to active-high 7-segment glyph with blank/dash overrides
module stopwatch_seg_decoder
   import stopwatch_display_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (digit_i == DIGIT_E) begin
         seg_o = SEG_E;
      end else if (digit_i <= 4'd9) begin
         seg_o = SEG_DIGIT[digit_i];
      end
   end

endmodule

// File: rtl/stopwatch_hex_display.sv
// rtl/stopwatch_hex_display.sv - stopwatch count to six 7-segment displays with blink and adjust dash
// Optional: STOPWATCH_LEADING_ZERO_BLANK_EN blanks a zero tens-of-minutes digit.
module stopwatch_hex_display
   import stopwatch_display_pkg::*;
#(
   parameter int unsigned BLINK_HALF_PERIOD = 50,
   parameter bit          SEG_ACTIVE_LOW    = 1'b1
) (
   input  logic       CLK_100Hz,
   input  logic       reset_n,
   input  logic [6:0] stopwatch_unit_mins,
   input  logic [5:0] stopwatch_unit_secs,
   input  logic [6:0] stopwatch_unit_decs,
   input  logic       stopwatch_overflow,
   input  logic       adjust,
   output logic [6:0] HEX5,
   output logic [6:0] HEX4,
   output logic [6:0] HEX3,
   output logic [6:0] HEX2,
   output logic [6:0] HEX1,
   output logic [6:0] HEX0,
   output logic       display_update
);

   localparam logic [2:0] LAST_SHIFT = 3'(CONV_SHIFTS - 1);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF_PERIOD - 1);
   localparam logic [6:0] POL_MASK   = {7{SEG_ACTIVE_LOW}};

   conv_state_e                 state_q, state_d;
   logic [2:0]                  shift_cnt_q, shift_cnt_d;
   logic [SR_W-1:0]             mins_sr_q, mins_sr_d;
   logic [SR_W-1:0]             secs_sr_q, secs_sr_d;
   logic [SR_W-1:0]             decs_sr_q, decs_sr_d;
   logic                        mins_err_q, mins_err_d;
   logic                        decs_err_q, decs_err_d;
   logic [DIGIT_COUNT-1:0][3:0] digit_q, digit_d;
   logic                        valid_q, valid_d;
   logic [7:0]                  blink_cnt_q, blink_cnt_d;
   logic                        phase_q, phase_d;
   logic                        update_q, update_d;
   logic [DIGIT_COUNT-1:0][6:0] hex_q, hex_d, glyph;
   logic [DIGIT_COUNT-1:0]      blank_vec, dash_vec;
   logic                        lead_zero;

   always_ff @(posedge CLK_100Hz or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= CAPTURE;
         shift_cnt_q <= '0;
         mins_sr_q   <= '0;
         secs_sr_q   <= '0;
         decs_sr_q   <= '0;
         mins_err_q  <= 1'b0;
         decs_err_q  <= 1'b0;
         digit_q     <= '0;
         valid_q     <= 1'b0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         update_q    <= 1'b0;
         hex_q       <= {DIGIT_COUNT{SEG_BLANK ^ POL_MASK}};
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         mins_sr_q   <= mins_sr_d;
         secs_sr_q   <= secs_sr_d;
         decs_sr_q   <= decs_sr_d;
         mins_err_q  <= mins_err_d;
         decs_err_q  <= decs_err_d;
         digit_q     <= digit_d;
         valid_q     <= valid_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         update_q    <= update_d;
         hex_q       <= hex_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_cnt_d = shift_cnt_q;
      mins_sr_d   = mins_sr_q;
      secs_sr_d   = secs_sr_q;
      decs_sr_d   = decs_sr_q;
      mins_err_d  = mins_err_q;
      decs_err_d  = decs_err_q;
      digit_d     = digit_q;
      valid_d     = valid_q;
      update_d    = 1'b0;
      unique case (state_q)
         CAPTURE: begin
            mins_sr_d   = {8'd0, stopwatch_unit_mins};
            secs_sr_d   = {9'd0, stopwatch_unit_secs};
            decs_sr_d   = {8'd0, stopwatch_unit_decs};
            mins_err_d  = (stopwatch_unit_mins > 7'd99);
            decs_err_d  = (stopwatch_unit_decs > 7'd99);
            shift_cnt_d = '0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            mins_sr_d = dabble_step(mins_sr_q);
            secs_sr_d = dabble_step(secs_sr_q);
            decs_sr_d = dabble_step(decs_sr_q);
            if (shift_cnt_q == LAST_SHIFT) begin
               state_d = COMMIT;
            end else begin
               shift_cnt_d = shift_cnt_q + 3'd1;
            end
         end
         COMMIT: begin
            digit_d[5] = mins_err_q ? DIGIT_E : mins_sr_q[14:11];
            digit_d[4] = mins_err_q ? DIGIT_E : mins_sr_q[10:7];
            digit_d[3] = secs_sr_q[14:11];
            digit_d[2] = secs_sr_q[10:7];
            digit_d[1] = decs_err_q ? DIGIT_E : decs_sr_q[14:11];
            digit_d[0] = decs_err_q ? DIGIT_E : decs_sr_q[10:7];
            valid_d    = 1'b1;
            update_d   = 1'b1;
            state_d    = CAPTURE;
         end
         default: state_d = CAPTURE;
      endcase
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (!stopwatch_overflow) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 8'd1;
      end
   end

`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
   // An out-of-range field holds DIGIT_E, so a zero here implies mins is in range
   assign lead_zero = (digit_d[5] == 4'd0);
`else
   assign lead_zero = 1'b0;
`endif

   // Outputs follow next-state values so HEX changes on the same edge as the digit load
   always_comb begin
      blank_vec = {DIGIT_COUNT{phase_d | ~valid_d}};
      blank_vec[DIGIT_COUNT-1] = blank_vec[DIGIT_COUNT-1] | lead_zero;
      dash_vec = '0;
      dash_vec[1:0] = {2{adjust}};
      for (int i = 0; i < DIGIT_COUNT; i++) begin
         hex_d[i] = glyph[i] ^ POL_MASK;
      end
   end

   for (genvar g = 0; g < DIGIT_COUNT; g++) begin : g_dec
      stopwatch_seg_decoder u_dec (
         .digit_i (digit_d[g]),
         .blank_i (blank_vec[g]),
         .dash_i  (dash_vec[g]),
         .seg_o   (glyph[g])
      );
   end

   assign HEX5           = hex_q[5];
   assign HEX4           = hex_q[4];
   assign HEX3           = hex_q[3];
   assign HEX2           = hex_q[2];
   assign HEX1           = hex_q[1];
   assign HEX0           = hex_q[0];
   assign display_update = update_q;

endmodule
